// File: rtl/glb_pkg.sv
// Shared types and sizing helpers for the global-buffer data loader and its controller.
package glb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_FREE
  } ld_state_e;

  localparam int CH_W = 8;

  function automatic int calc_nb(input int bufw, input int bufh);
    return bufw * bufh;
  endfunction

  function automatic int calc_blk_per_ch(input int ih, input int bufh);
    return ih / bufh;
  endfunction

  function automatic int calc_cnt_w(input int nb);
    return $clog2(nb) + 1;
  endfunction

  function automatic int calc_blk_w(input int ih, input int bufh);
    return CH_W + $clog2(ih / bufh);
  endfunction

endpackage

// File: rtl/glb_addr_gen.sv
// Read-address generator: base + blk*NB + issued, where issued advances on each accepted request.
module glb_addr_gen
  import glb_pkg::*;
#(
  parameter int AW = 32,
  parameter int NB = 128,
  parameter int CW = 8,
  parameter int BW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          base_we,
  input  logic [AW-1:0] base_in,
  input  logic          start,
  input  logic          grant,
  input  logic          blk_next,
  input  logic          resume,
  output logic [CW-1:0] issued,
  output logic [BW-1:0] blk,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base   <= '0;
      blk    <= '0;
      issued <= '0;
    end else if (en) begin
      if (base_we) base <= base_in;
      if (start) begin
        blk    <= '0;
        issued <= '0;
      end else begin
        if (blk_next) blk <= blk + BW'(1);
        if (resume) issued <= '0;
        else if (grant) issued <= issued + CW'(1);
      end
    end
  end

  // Modulo-2^AW arithmetic: the map may straddle the top of the address space.
  assign addr = base + AW'(blk) * AW'(NB) + AW'(issued);

endmodule

// File: rtl/glb_data_loader.sv
// Feature-map loader: streams ch_num maps from memory into the line buffer block by block.
module glb_data_loader
  import glb_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int IW   = 32,
  parameter int IH   = 32,
  parameter int BUFW = 32,
  parameter int BUFH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sys_ena,
  input  logic                    data_load,
  input  logic                    data_init_addr_en,
  input  logic [AW-1:0]           data_init_addr,
  input  logic [7:0]              ch_num,
  output logic                    mem_req,
  output logic [AW-1:0]           mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    buf_we,
  output logic [$clog2(BUFH)-1:0] buf_wrow,
  output logic [$clog2(BUFW)-1:0] buf_wcol,
  output logic [DW-1:0]           buf_wdata,
  input  logic                    buf_free,
  output logic                    blkend,
  output logic                    mapend,
  output logic                    busy
);

  localparam int NB  = calc_nb(BUFW, BUFH);
  localparam int BPC = calc_blk_per_ch(IH, BUFH);
  localparam int CW  = calc_cnt_w(NB);
  localparam int BW  = calc_blk_w(IH, BUFH);
  localparam int RW  = $clog2(BUFH);
  localparam int LW  = $clog2(BUFW);
  localparam logic [CW-1:0] NB_C = CW'(NB);
  localparam logic [CW-1:0] IW_C = CW'(IW);

  ld_state_e       state, state_d;
  logic [CH_W-1:0] ch_lat, eff_ch;
  logic [CW-1:0]   wcnt, issued;
  logic [BW-1:0]   blk, last_blk;
  logic            start, grant, wr_fire, blk_done, is_last, resume;
  logic            we_q, blkend_q, mapend_q;

  assign eff_ch   = (ch_lat == '0) ? CH_W'(1) : ch_lat;
  assign last_blk = BW'(eff_ch) * BW'(BPC) - BW'(1);
  assign start    = (state == IDLE) && data_load;
  assign mem_req  = sys_ena && (state == FETCH) && (issued < NB_C);
  assign grant    = mem_req && mem_gnt;
  assign wr_fire  = (state == FETCH) && mem_rvalid;
  assign blk_done = wr_fire && (wcnt == NB_C - CW'(1));
  assign is_last  = (blk == last_blk);
  assign resume   = (state == WAIT_FREE) && buf_free;

  glb_addr_gen #(
    .AW(AW),
    .NB(NB),
    .CW(CW),
    .BW(BW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (sys_ena),
    .base_we ((state == IDLE) && data_init_addr_en),
    .base_in (data_init_addr),
    .start   (start),
    .grant   (grant),
    .blk_next(blk_done && !is_last),
    .resume  (resume),
    .issued  (issued),
    .blk     (blk),
    .addr    (mem_addr)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (data_load) state_d = FETCH;
      FETCH:     if (blk_done) state_d = is_last ? IDLE : WAIT_FREE;
      WAIT_FREE: if (buf_free) state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else if (sys_ena) state <= state_d;
  end

  // Write side: one registered buffer write per returned word; wcnt splits into row/column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_lat    <= '0;
      wcnt      <= '0;
      we_q      <= 1'b0;
      blkend_q  <= 1'b0;
      mapend_q  <= 1'b0;
      buf_wrow  <= '0;
      buf_wcol  <= '0;
      buf_wdata <= '0;
    end else if (sys_ena) begin
      we_q     <= wr_fire;
      blkend_q <= blk_done;
      mapend_q <= blk_done && is_last;
      if (start) begin
        ch_lat <= ch_num;
        wcnt   <= '0;
      end else if (resume) begin
        wcnt <= '0;
      end else if (wr_fire) begin
        wcnt <= wcnt + CW'(1);
      end
      if (wr_fire) begin
        buf_wrow  <= RW'(wcnt / IW_C);
        buf_wcol  <= LW'(wcnt % IW_C);
        buf_wdata <= mem_rdata;
      end
    end
  end

  assign buf_we = we_q && sys_ena;
  assign blkend = blkend_q && sys_ena;
  assign mapend = mapend_q && sys_ena;
  assign busy   = (state != IDLE);

endmodule
